mem_bus_responder: RTL and testbench
====================================

// Module: mem_bus_responder
// PURPOSE
//  Memory-side responder for the CPU native memory bus (mem_valid/mem_ready handshake).
//  - Accepts one instruction-fetch or data transfer at a time, inserts programmable
//    wait states and performs byte-strobed writes into a local word-addressed SRAM.
//  - Returns read data and flags bad accesses on bus_err, which drives CPU irq[2]
//    (irq_buserror).
//  - Sits between the cpu core and on-chip RAM; also serves as the bench memory model.
// PARAMETERS
//  MEM_WORDS    1024          depth of local SRAM in 32-bit words (power of 2, >=2)
//  BASE_ADDR    32'h0000_0000 byte address of word 0; must be 4*MEM_WORDS aligned
//  RD_LATENCY   1             cycles from request accept to mem_ready, reads (>=1)
//  WR_LATENCY   1             cycles from request accept to mem_ready, writes (>=1)
// PORTS
//  clk        in   1   clock
//  rst_n      in   1   reset
//  mem_valid  in   1   master request; held high with stable addr/wdata/wstrb until ready
//  mem_instr  in   1   request is an instruction fetch (counted only, no functional effect)
//  mem_addr   in   32  byte address
//  mem_wdata  in   32  write data
//  mem_wstrb  in   4   byte write enables; 4'b0000 = read
//  mem_ready  out  1   one-cycle completion pulse
//  mem_rdata  out  32  read data, valid in the mem_ready cycle
//  bus_err    out  1   one-cycle pulse coincident with mem_ready on a faulted access
//  err_cnt    out  8   faulted-access count, saturates at 8'hFF
//  fetch_cnt  out  32  completed mem_instr transfers, wraps modulo 2^32
// BEHAVIOUR
//  Reset: rst_n is asynchronous and active-low; clk is the only clock. Reset forces:
//  - state IDLE, mem_ready=0, bus_err=0, mem_rdata=0, err_cnt=0, fetch_cnt=0
//  - SRAM contents are NOT reset
//  - a reset mid-transfer aborts it and performs no write
//  FSM states: IDLE, WAIT, RESP
//  - IDLE: on a posedge with mem_valid=1, latch addr/wdata/wstrb/instr and decode the
//    fault. Load wcnt = LAT-1, where LAT = RD_LATENCY if wstrb==0, else WR_LATENCY.
//    Go to RESP if LAT==1, else WAIT.
//  - WAIT: wcnt decrements each cycle; go to RESP when wcnt reaches 1.
//    If mem_valid drops while in WAIT, go to IDLE: no ready, no write, no count.
//  - RESP: mem_ready=1 for exactly one cycle, then IDLE.
//  Latency: mem_ready is high exactly LAT cycles after the accepting edge
//    (LAT=1 means ready in the cycle after mem_valid is first sampled).
//  Back-to-back: a new request is only accepted in IDLE. Minimum spacing between
//    ready pulses is LAT+1 cycles.
//  Fault if either holds:
//  - mem_addr[1:0] != 0 (misaligned)
//  - mem_addr < BASE_ADDR or mem_addr >= BASE_ADDR + 4*MEM_WORDS
//    (compare in 33 bits so the end address cannot wrap)
//  Fault response: mem_ready still pulses; bus_err pulses in the same cycle;
//    mem_rdata = 32'h0000_0000; no SRAM write; err_cnt += 1 (saturating).
//  Read: index = (mem_addr - BASE_ADDR) >> 2, truncated to log2(MEM_WORDS) bits.
//    mem_rdata is registered in the RESP cycle and holds its value until the next response.
//  Write: at the RESP edge, byte lane i is written with wdata[8i+7:8i] iff wstrb[i].
//  - Unstrobed bytes are unchanged.
//  - mem_rdata in a write response = 32'h0 (not the old contents).
//  fetch_cnt: +1 on every RESP with latched instr=1, faulted or not.
//  Inputs that change while mem_valid is held are ignored; the latched copy is used.
// STRUCTURE
//  Package riscv_mem_pkg:
//  - typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_resp_state_e
//  - localparam ERR_RDATA = 32'h0
//  - localparam BUS_ADDR_W = 32
//  - shared with the cpu core
//  Sub-module mem_sram_be:
//  - MEM_WORDS x 32 synchronous RAM, 4 byte-lane write enables, 1-cycle read
//  - read issued on entry to RESP-1 (or at accept when LAT==1) so data lands in RESP
// TESTING
//  1) RD_LATENCY=1: read 0x0000_0010 after preload 0xCAFE_F00D -> mem_ready 1 cycle
//     after accept, mem_rdata=0xCAFE_F00D, bus_err=0.
//  2) WR_LATENCY=3: write 0x0000_0004, wdata 0x1122_3344, wstrb 4'b0101, over word
//     0xFFFF_FFFF -> ready 3 cycles after accept; readback 0xFF22_FF44.
//  3) Read 0x0000_1000 (MEM_WORDS=1024), then read 0x0000_0002 -> each gets a ready
//     pulse with bus_err=1, rdata=0, SRAM unchanged, err_cnt=2.
//  4) RD_LATENCY=4: drop mem_valid 2 cycles after accept -> no ready pulse, FSM in
//     IDLE; the next request completes normally.
//  5) Assert rst_n=0 during WAIT of a write -> mem_ready/bus_err go 0 at once, target
//     word keeps its old value, counters are 0.
//  6) 300 faulted accesses + 5 mem_instr fetches -> err_cnt=8'hFF (saturated),
//     fetch_cnt = 5 + faulted fetches.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the CPU native memory bus and its memory-side responder.
// Contents: responder FSM state type, error read-data value, bus address width,
// wait-state counter width and a saturating 8-bit increment helper.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_resp_state_e;

  localparam logic [31:0] ERR_RDATA  = 32'h0000_0000;
  localparam int          BUS_ADDR_W = 32;
  localparam int          LAT_CNT_W  = 16;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mem_sram_be.sv
// Word-addressed synchronous SRAM with four byte-lane write enables and a
// registered (one-cycle) read port. Contents are not reset.
// Ports:
//   clk        clock
//   i_rd_en    capture word i_rd_idx into o_rd_data at the next edge
//   i_rd_idx   read word index
//   i_wr_en    write enable
//   i_wr_idx   write word index
//   i_wr_be    byte-lane enables for the write
//   i_wr_data  write data
//   o_rd_data  registered read data
module mem_sram_be #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_idx,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_idx,
  input  logic [3:0]    i_wr_be,
  input  logic [31:0]   i_wr_data,
  output logic [31:0]   o_rd_data
);

  logic [31:0] r_mem [WORDS];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wr_be[b]) r_mem[i_wr_idx][8*b +: 8] <= i_wr_data[8*b +: 8];
      end
    end
    if (i_rd_en) o_rd_data <= r_mem[i_rd_idx];
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the CPU native memory bus (valid/ready handshake).
// Accepts one transfer at a time, inserts RD_LATENCY/WR_LATENCY wait states,
// performs byte-strobed writes into a local SRAM and flags misaligned or
// out-of-window accesses on bus_err (drives the CPU bus-error interrupt).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   mem_valid             request, held with stable payload until mem_ready
//   mem_instr             request is an instruction fetch (counted only)
//   mem_addr/wdata/wstrb  byte address, write data, byte enables (0 = read)
//   mem_ready             one-cycle completion pulse
//   mem_rdata             read data, valid with mem_ready, held until next response
//   bus_err               one-cycle fault pulse alongside mem_ready
//   err_cnt               saturating count of faulted accesses
//   fetch_cnt             wrapping count of completed instruction fetches
module mem_bus_responder
  import riscv_mem_pkg::*;
#(
  parameter int          MEM_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          RD_LATENCY = 1,
  parameter int          WR_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        bus_err,
  output logic [7:0]  err_cnt,
  output logic [31:0] fetch_cnt
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [LAT_CNT_W-1:0] RD_LAT = LAT_CNT_W'(RD_LATENCY);
  localparam logic [LAT_CNT_W-1:0] WR_LAT = LAT_CNT_W'(WR_LATENCY);
  // 33-bit end of window so a window touching 2^32 cannot wrap to zero
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(MEM_WORDS) << 2);

  mem_resp_state_e r_state, w_next;

  logic [31:0]          r_addr, r_wdata, r_rdata_hold;
  logic [3:0]           r_wstrb;
  logic                 r_instr, r_fault;
  logic [LAT_CNT_W-1:0] r_wcnt;

  logic                 w_accept, w_fault_in, w_rd_en, w_wr_en;
  logic [LAT_CNT_W-1:0] w_lat_in;
  logic [31:0]          w_rd_addr, w_sram_q, w_resp_data;
  logic [AW-1:0]        w_rd_idx, w_wr_idx;

  assign w_fault_in = (mem_addr[1:0] != 2'b00)
                   || ({1'b0, mem_addr} < {1'b0, BASE_ADDR})
                   || ({1'b0, mem_addr} >= END_ADDR);
  assign w_lat_in   = (mem_wstrb == 4'b0000) ? RD_LAT : WR_LAT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    mem_ready = 1'b0;
    bus_err   = 1'b0;
    case (r_state)
      IDLE: begin
        if (mem_valid) begin
          w_accept = 1'b1;
          w_next   = (w_lat_in == LAT_CNT_W'(1)) ? RESP : WAIT;
        end
      end
      WAIT: begin
        // master withdrew the request: abandon silently
        if (!mem_valid)                    w_next = IDLE;
        else if (r_wcnt == LAT_CNT_W'(1))  w_next = RESP;
      end
      RESP: begin
        mem_ready = 1'b1;
        bus_err   = r_fault;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_instr      <= 1'b0;
      r_fault      <= 1'b0;
      r_wcnt       <= '0;
      r_rdata_hold <= '0;
      err_cnt      <= '0;
      fetch_cnt    <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= mem_addr;
        r_wdata <= mem_wdata;
        r_wstrb <= mem_wstrb;
        r_instr <= mem_instr;
        r_fault <= w_fault_in;
        r_wcnt  <= w_lat_in - LAT_CNT_W'(1);
      end else if (r_state == WAIT) begin
        r_wcnt <= r_wcnt - LAT_CNT_W'(1);
      end
      if (r_state == RESP) begin
        r_rdata_hold <= w_resp_data;
        if (r_fault) err_cnt <= sat_inc8(err_cnt);
        if (r_instr) fetch_cnt <= fetch_cnt + 32'd1;
      end
    end
  end

  // The read is launched on the edge that enters RESP; at accept the latched
  // address is not yet valid, so the live bus address is used in IDLE.
  assign w_rd_addr = (r_state == IDLE) ? mem_addr : r_addr;
  assign w_rd_idx  = AW'((w_rd_addr - BASE_ADDR) >> 2);
  assign w_rd_en   = (w_next == RESP) && (r_state != RESP);
  assign w_wr_idx  = AW'((r_addr - BASE_ADDR) >> 2);
  assign w_wr_en   = (r_state == RESP) && !r_fault && (r_wstrb != 4'b0000);

  mem_sram_be #(
    .WORDS(MEM_WORDS),
    .AW   (AW)
  ) u_sram (
    .clk      (clk),
    .i_rd_en  (w_rd_en),
    .i_rd_idx (w_rd_idx),
    .i_wr_en  (w_wr_en),
    .i_wr_idx (w_wr_idx),
    .i_wr_be  (r_wstrb),
    .i_wr_data(r_wdata),
    .o_rd_data(w_sram_q)
  );

  assign w_resp_data = (r_fault || (r_wstrb != 4'b0000)) ? ERR_RDATA : w_sram_q;
  assign mem_rdata   = (r_state == RESP) ? w_resp_data : r_rdata_hold;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed self-checking bench for mem_bus_responder.
// dut_a: RD_LATENCY=1, WR_LATENCY=3. dut_b: RD_LATENCY=4, WR_LATENCY=1.
// Both share clock, reset and payload; each has its own mem_valid.
module tb_mem_bus_responder;
  import riscv_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_a = 1'b0, valid_b = 1'b0, instr = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  wstrb = '0;

  logic        rdy_a, err_a, rdy_b, err_b;
  logic [31:0] rdata_a, rdata_b, fcnt_a, fcnt_b;
  logic [7:0]  errc_a, errc_b;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  mem_bus_responder #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .RD_LATENCY(1), .WR_LATENCY(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .mem_valid(valid_a), .mem_instr(instr), .mem_addr(addr),
    .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_ready(rdy_a), .mem_rdata(rdata_a),
    .bus_err(err_a), .err_cnt(errc_a), .fetch_cnt(fcnt_a));

  mem_bus_responder #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .RD_LATENCY(4), .WR_LATENCY(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .mem_valid(valid_b), .mem_instr(instr), .mem_addr(addr),
    .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_ready(rdy_b), .mem_rdata(rdata_b),
    .bus_err(err_b), .err_cnt(errc_b), .fetch_cnt(fcnt_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One full transfer; lat = cycles from accepting edge to mem_ready (0 on timeout).
  // The *_n outputs are sampled one cycle after the ready pulse.
  task automatic xfer(input bit sel_b, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic ins,
                      output int lat, output logic [31:0] rd, output logic er,
                      output logic rdy_n, output logic er_n, output logic [31:0] rd_n);
    @(negedge clk);
    addr = a; wdata = d; wstrb = s; instr = ins;
    if (sel_b) valid_b = 1'b1; else valid_a = 1'b1;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if ((sel_b ? rdy_b : rdy_a) === 1'b1) begin
        lat = n;
        break;
      end
    end
    rd = sel_b ? rdata_b : rdata_a;
    er = sel_b ? err_b : err_a;
    valid_a = 1'b0; valid_b = 1'b0;
    @(posedge clk); #1;
    rdy_n = sel_b ? rdy_b : rdy_a;
    er_n  = sel_b ? err_b : err_a;
    rd_n  = sel_b ? rdata_b : rdata_a;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [31:0] rd, rd_n;
    logic        er, rdy_n, er_n, seen;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, rdy_a}, 32'd0);
    check("rst_bus_err", {31'b0, err_a}, 32'd0);
    check("rst_rdata", rdata_a, 32'd0);
    check("rst_err_cnt", {24'b0, errc_a}, 32'd0);
    check("rst_fetch_cnt", fcnt_a, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // preload through the bus
    xfer(0, 32'h10,  32'hCAFE_F00D, 4'hF, 0, lat, rd, er, rdy_n, er_n, rd_n);
    check("wr_full_lat", lat, 32'd3);
    xfer(0, 32'h4,   32'hFFFF_FFFF, 4'hF, 0, lat, rd, er, rdy_n, er_n, rd_n);
    xfer(0, 32'h0,   32'h0123_4567, 4'hF, 0, lat, rd, er, rdy_n, er_n, rd_n);
    xfer(0, 32'hFFC, 32'hA5A5_5A5A, 4'hF, 0, lat, rd, er, rdy_n, er_n, rd_n);

    // 1) read, latency 1, fetch counted
    xfer(0, 32'h10, 32'h0, 4'h0, 1, lat, rd, er, rdy_n, er_n, rd_n);
    check("t1_lat", lat, 32'd1);
    check("t1_rdata", rd, 32'hCAFE_F00D);
    check("t1_bus_err", {31'b0, er}, 32'd0);
    check("t1_ready_one_cycle", {31'b0, rdy_n}, 32'd0);
    check("t1_rdata_hold", rd_n, 32'hCAFE_F00D);
    check("t1_fetch_cnt", fcnt_a, 32'd1);

    // 2) strobed write, latency 3, then readback
    xfer(0, 32'h4, 32'h1122_3344, 4'b0101, 0, lat, rd, er, rdy_n, er_n, rd_n);
    check("t2_lat", lat, 32'd3);
    check("t2_wr_rdata", rd, 32'd0);
    check("t2_bus_err", {31'b0, er}, 32'd0);
    xfer(0, 32'h4, 32'h0, 4'h0, 0, lat, rd, er, rdy_n, er_n, rd_n);
    check("t2_readback", rd, 32'hFF22_FF44);

    // last word in window is legal
    xfer(0, 32'hFFC, 32'h0, 4'h0, 0, lat, rd, er, rdy_n, er_n, rd_n);
    check("last_word_err", {31'b0, er}, 32'd0);
    check("last_word_rdata", rd, 32'hA5A5_5A5A);

    // 3) faults: out of window, misaligned, and faulted writes
    xfer(0, 32'h1000, 32'h0, 4'h0, 0, lat, rd, er, rdy_n, er_n, rd_n);
    check("t3_oob_lat", lat, 32'd1);
    check("t3_oob_err", {31'b0, er}, 32'd1);
    check("t3_oob_rdata", rd, 32'd0);
    check("t3_err_one_cycle", {31'b0, er_n}, 32'd0);
    xfer(0, 32'h2, 32'h0, 4'h0, 0, lat, rd, er, rdy_n, er_n, rd_n);
    check("t3_mis_err", {31'b0, er}, 32'd1);
    check("t3_mis_rdata", rd, 32'd0);
    xfer(0, 32'h1000, 32'hDEAD_BEEF, 4'hF, 0, lat, rd, er, rdy_n, er_n, rd_n);
    check("t3_oob_wr_lat", lat, 32'd3);
    check("t3_oob_wr_err", {31'b0, er}, 32'd1);
    xfer(0, 32'h6, 32'hDEAD_BEEF, 4'hF, 0, lat, rd, er, rdy_n, er_n, rd_n);
    check("t3_mis_wr_err", {31'b0, er}, 32'd1);
    check("t3_err_cnt", {24'b0, errc_a}, 32'd4);
    xfer(0, 32'h0, 32'h0, 4'h0, 0, lat, rd, er, rdy_n, er_n, rd_n);
    check("t3_word0_kept", rd, 32'h0123_4567);
    xfer(0, 32'h4, 32'h0, 4'h0, 0, lat, rd, er, rdy_n, er_n, rd_n);
    check("t3_word1_kept", rd, 32'hFF22_FF44);
    check("t3_fetch_cnt", fcnt_a, 32'd1);

    // 4) dut_b: abandoned read leaves no trace, next read completes
    xfer(1, 32'h20, 32'h5555_AAAA, 4'hF, 0, lat, rd, er, rdy_n, er_n, rd_n);
    check("t4_wr_lat", lat, 32'd1);
    @(negedge clk);
    addr = 32'h20; wstrb = 4'h0; instr = 1'b1; valid_b = 1'b1;
    seen = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      seen = seen | rdy_b;
    end
    valid_b = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen = seen | rdy_b;
    end
    check("t4_no_ready", {31'b0, seen}, 32'd0);
    check("t4_state_idle", 32'(dut_b.r_state), 32'(IDLE));
    check("t4_no_fetch", fcnt_b, 32'd0);
    xfer(1, 32'h20, 32'h0, 4'h0, 1, lat, rd, er, rdy_n, er_n, rd_n);
    check("t4_rd_lat", lat, 32'd4);
    check("t4_rdata", rd, 32'h5555_AAAA);
    check("t4_fetch_cnt", fcnt_b, 32'd1);

    // 5) reset during WAIT of a write
    @(negedge clk);
    addr = 32'h10; wdata = 32'h0; wstrb = 4'hF; instr = 1'b1; valid_a = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t5_ready", {31'b0, rdy_a}, 32'd0);
    check("t5_bus_err", {31'b0, err_a}, 32'd0);
    check("t5_err_cnt", {24'b0, errc_a}, 32'd0);
    check("t5_fetch_cnt", fcnt_a, 32'd0);
    check("t5_rdata", rdata_a, 32'd0);
    valid_a = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    xfer(0, 32'h10, 32'h0, 4'h0, 0, lat, rd, er, rdy_n, er_n, rd_n);
    check("t5_word_kept", rd, 32'hCAFE_F00D);

    // 6) err_cnt saturation and fetch counting across faults
    for (int i = 0; i < 300; i++) begin
      xfer(0, 32'h2000, 32'h0, 4'h0, (i < 10), lat, rd, er, rdy_n, er_n, rd_n);
      if (i == 253) check("t6_err_cnt_254", {24'b0, errc_a}, 32'hFE);
      if (i == 254) check("t6_err_cnt_255", {24'b0, errc_a}, 32'hFF);
    end
    check("t6_err_cnt_sat", {24'b0, errc_a}, 32'hFF);
    for (int i = 0; i < 5; i++) begin
      xfer(0, 32'h10, 32'h0, 4'h0, 1, lat, rd, er, rdy_n, er_n, rd_n);
    end
    check("t6_fetch_err", {31'b0, er}, 32'd0);
    check("t6_fetch_cnt", fcnt_a, 32'd15);
    check("t6_err_cnt_final", {24'b0, errc_a}, 32'hFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
